alu_share_ctrl: RTL



---
 rtl/alu_share_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin front end that lets two requesters share one combinational alu.
// Registers the winning operation onto the alu inputs and returns the result over a valid/ready channel.
//
//   state | meaning
//   IDLE  | arbitrate; accept one requester and load alu_* registers
//   EXEC  | alu inputs stable; capture alu_out and the divide-by-zero flag
//   RESP  | hold response until rsp_ready, then count it
module alu_share_ctrl #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [5:0]                    req_sel,
  input  logic [2*DATA_WIDTH-1:0]       req_in0,
  input  logic [2*DATA_WIDTH-1:0]       req_in1,
  output logic [2:0]                    alu_sel,
  output logic [DATA_WIDTH-1:0]         alu_in0,
  output logic [DATA_WIDTH-1:0]         alu_in1,
  input  logic signed [2*DATA_WIDTH:0]  alu_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [2*DATA_WIDTH:0]         rsp_data,
  output logic                          rsp_divzero,
  output logic                          busy,
  output logic [7:0]                    op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [2:0]              alu_sel_q, alu_sel_d;
  logic [DATA_WIDTH-1:0]   alu_in0_q, alu_in0_d;
  logic [DATA_WIDTH-1:0]   alu_in1_q, alu_in1_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [2*DATA_WIDTH:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_divzero_q, rsp_divzero_d;
  logic [7:0]              op_count_q, op_count_d;
  logic                    grant;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    alu_sel_d     = alu_sel_q;
    alu_in0_d     = alu_in0_q;
    alu_in1_d     = alu_in1_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_divzero_d = rsp_divzero_q;
    op_count_d    = op_count_q;
    req_ready     = 2'b00;
    grant         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          // on a tie the requester that did not win last time goes first
          grant        = (&req_valid) ? ~last_grant_q : req_valid[1];
          req_ready    = grant ? 2'b10 : 2'b01;
          alu_sel_d    = grant ? req_sel[5:3] : req_sel[2:0];
          alu_in0_d    = grant ? req_in0[2*DATA_WIDTH-1:DATA_WIDTH] : req_in0[DATA_WIDTH-1:0];
          alu_in1_d    = grant ? req_in1[2*DATA_WIDTH-1:DATA_WIDTH] : req_in1[DATA_WIDTH-1:0];
          last_grant_d = grant;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d    = alu_out;
        rsp_id_d      = last_grant_q;
        // opcodes 3 (div) and 7 (mod) share the low bits 2'b11
        rsp_divzero_d = (alu_sel_q[1:0] == 2'b11) && (alu_in1_q == '0);
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      alu_sel_q     <= '0;
      alu_in0_q     <= '0;
      alu_in1_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_divzero_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      alu_sel_q     <= alu_sel_d;
      alu_in0_q     <= alu_in0_d;
      alu_in1_q     <= alu_in1_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_divzero_q <= rsp_divzero_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_sel     = alu_sel_q;
  assign alu_in0     = alu_in0_q;
  assign alu_in1     = alu_in1_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_divzero = rsp_divzero_q;
  assign busy        = (state_q != ST_IDLE);
  assign op_count    = op_count_q;

endmodule
